// File: rtl/display_scan_ctrl.sv
// Four-digit time-multiplexed 7-segment scanner: steers the external nibble mux,
// hex-decodes the returned nibble and strobes one anode per slot after a blanking gap.
module display_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] nibble_in,
    input  logic [3:0] dp_in,
    input  logic [3:0] digit_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int            CW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    sel_next;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          tick_next;

    function automatic logic [6:0] hexdecode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel;
        tick_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                sel_next = '0;
                if (en) state_next = BLANK;
            end
            BLANK: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sel_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == BLANK_LAST) state_next = SHOW;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sel_next   = '0;
                end else if (cnt == SLOT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    sel_next   = sel + 2'd1;
                    tick_next  = (sel == 2'd3);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                sel_next   = '0;
            end
        endcase

        // Anodes follow the upcoming state so they are already off on the sel-change edge.
        an_next = 4'b1111;
        if (state_next == SHOW && digit_mask[sel_next]) an_next = ~(4'b0001 << sel_next);

        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (state_next != IDLE) begin
            seg_next = hexdecode(nibble_in);
            dp_next  = ~dp_in[sel];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state      <= state_next;
            cnt        <= cnt_next;
            sel        <= sel_next;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_tick <= tick_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a position-in-frame model predicts every
// output each cycle, plus directed scenarios with literal expectations and a random phase.
module tb_display_scan_ctrl;

    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       en         = 1'b0;
    logic [3:0] dp_in      = 4'h0;
    logic [3:0] digit_mask = 4'hF;
    logic [3:0] nibble_in;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;
    logic [3:0] digits [4];

    // Combinational 4:1 mux stub returning the digit chosen by sel.
    assign nibble_in = digits[sel];

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .nibble_in  (nibble_in),
        .dp_in      (dp_in),
        .digit_mask (digit_mask),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: while running, m_pos counts cycles since the scan started at digit 0.
    bit         m_run  = 1'b0;
    int         m_pos  = 0;
    bit         cmp_on = 1'b0;
    logic [1:0] e_sel  = 2'd0;
    logic [3:0] e_an   = 4'hF;
    logic [6:0] e_seg  = 7'h7F;
    logic       e_dp   = 1'b1;
    logic       e_tick = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_dark();
        e_sel  = 2'd0;
        e_an   = 4'hF;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        e_tick = 1'b0;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pos = 0;
        model_dark();
    endtask

    // Called right after each rising edge with the inputs that were stable at that edge.
    task automatic model_step();
        logic [1:0] s_before;
        logic [1:0] s;
        int         c;
        s_before = m_run ? 2'((m_pos / P) % 4) : 2'd0;
        if (reset) m_run = 1'b0;
        else if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (!en) m_run = 1'b0;
        else m_pos++;

        if (!m_run) model_dark();
        else begin
            s      = 2'((m_pos / P) % 4);
            c      = m_pos % P;
            e_sel  = s;
            e_an   = (c >= B && digit_mask[s]) ? ~(4'b0001 << s) : 4'hF;
            e_tick = (m_pos > 0) && (m_pos % FRAME == 0);
            e_seg  = HEX[digits[s_before]];
            e_dp   = ~dp_in[s_before];
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("sel", 8'(sel), 8'(e_sel));
            check("an", 8'(an), 8'(e_an));
            check("seg", 8'(seg), 8'(e_seg));
            check("dp", 8'(dp), 8'(e_dp));
            check("frame_tick", 8'(frame_tick), 8'(e_tick));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_until(input int frame_pos, input string label);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_run && (m_pos % FRAME == frame_pos)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s: frame position %0d never reached", label, frame_pos);
    endtask

    initial begin
        digits = '{4'h0, 4'h1, 4'h8, 4'hF};
        model_reset();
        #1 reset = 1'b1;
        #2;
        check("rst_an", 8'(an), 8'h0F);
        check("rst_seg", 8'(seg), 8'h7F);
        check("rst_dp", 8'(dp), 8'h01);
        check("rst_sel", 8'(sel), 8'h00);
        check("rst_tick", 8'(frame_tick), 8'h00);
        cmp_on = 1'b1;
        run(2);
        reset = 1'b0;
        en    = 1'b1;

        // Basic scan with mux A=0, B=1, C=8, D=F.
        tick();
        check("start_sel", 8'(sel), 8'h00);
        check("start_an", 8'(an), 8'h0F);
        run(2);
        check("d0_an", 8'(an), 8'b1110);
        check("d0_seg", 8'(seg), 8'b1000000);
        run(8);
        check("d1_an", 8'(an), 8'b1101);
        check("d1_seg", 8'(seg), 8'b1111001);
        run(8);
        check("d2_an", 8'(an), 8'b1011);
        check("d2_seg", 8'(seg), 8'b0000000);
        run(8);
        check("d3_an", 8'(an), 8'b0111);
        check("d3_seg", 8'(seg), 8'b0001110);
        run(6);
        check("wrap_tick", 8'(frame_tick), 8'h01);
        check("wrap_sel", 8'(sel), 8'h00);
        tick();
        check("tick_one_cycle", 8'(frame_tick), 8'h00);
        run(40);

        // Masked digits 1 and 3 stay dark.
        digit_mask = 4'b0101;
        run_until(10, "mask1");
        check("mask_d1_an", 8'(an), 8'h0F);
        run_until(18, "mask2");
        check("mask_d2_an", 8'(an), 8'b1011);
        run(20);

        // Decimal point on digit 3 only.
        digit_mask = 4'hF;
        dp_in      = 4'b1000;
        run_until(26, "dp3");
        check("dp_d3", 8'(dp), 8'h00);
        run_until(2, "dp0");
        check("dp_d0", 8'(dp), 8'h01);

        // Enable dropped at slot cycle 5 of digit 2.
        dp_in = 4'h0;
        run_until(21, "en_drop");
        en = 1'b0;
        tick();
        check("off_an", 8'(an), 8'h0F);
        check("off_seg", 8'(seg), 8'h7F);
        check("off_sel", 8'(sel), 8'h00);
        check("off_tick", 8'(frame_tick), 8'h00);
        run(3);
        en = 1'b1;
        tick();
        check("restart_sel", 8'(sel), 8'h00);
        check("restart_an", 8'(an), 8'h0F);
        run(2);
        check("restart_d0_an", 8'(an), 8'b1110);

        // Asynchronous reset mid-SHOW of digit 3.
        run_until(28, "rst_mid");
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_an", 8'(an), 8'h0F);
        check("async_seg", 8'(seg), 8'h7F);
        check("async_sel", 8'(sel), 8'h00);
        check("async_dp", 8'(dp), 8'h01);
        run(2);
        reset = 1'b0;
        tick();
        run(31);
        check("post_rst_no_tick", 8'(frame_tick), 8'h00);
        tick();
        check("post_rst_tick", 8'(frame_tick), 8'h01);

        // Randomized operation: digit values, mask, dp, enable and reset pulses.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) digits[2'($urandom)] = 4'($urandom);
            if ($urandom_range(0, 19) == 0) digit_mask = 4'($urandom);
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
            if (en) begin
                if ($urandom_range(0, 59) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) en = 1'b1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            tick();
        end

        @(posedge clk);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
